// File: rtl/rgb_mixer_pkg.sv
// Shared defaults, level type and the saturating/wrapping level-step helper
// for the rgb_mixer_n encoder-to-PWM mixer.
package rgb_mixer_pkg;

  localparam int unsigned DEF_LEVEL_WIDTH     = 8;
  localparam int unsigned DEF_DEBOUNCE_CYCLES = 7;
  localparam int unsigned DEF_STEP            = 1;
  localparam int unsigned MAX_LEVEL_WIDTH     = 16;

  typedef logic [DEF_LEVEL_WIDTH-1:0] level_t;
  typedef logic [MAX_LEVEL_WIDTH:0]   wide_level_t;

  // One extra bit of headroom lets the overflow/underflow be seen before
  // deciding between clamping and truncating to 'width' bits.
  function automatic wide_level_t level_step(
    input wide_level_t cur,
    input wide_level_t step,
    input logic        inc,
    input logic        sat,
    input int unsigned width
  );
    wide_level_t lim;
    wide_level_t res;
    lim = wide_level_t'((32'd1 << width) - 32'd1);
    if (inc) begin
      res = cur + step;
      if (sat && (res > lim)) res = lim;
    end else begin
      if (sat && (step > cur)) res = '0;
      else                     res = cur - step;
    end
    return res & lim;
  endfunction

endpackage

// File: rtl/rgb_mixer_channel.sv
// One mixer channel: encoder synchroniser, A/B debouncers, x1 decoder,
// double-buffered shadow/active level and registered PWM comparator.
module rgb_mixer_channel import rgb_mixer_pkg::*; #(
  parameter int unsigned LEVEL_WIDTH     = DEF_LEVEL_WIDTH,
  parameter int unsigned DEBOUNCE_CYCLES = DEF_DEBOUNCE_CYCLES,
  parameter int unsigned STEP            = DEF_STEP,
  parameter bit          SATURATE        = 1'b1
) (
  input  logic                   clk,
  input  logic                   reset,
  input  logic                   i_enc_a,
  input  logic                   i_enc_b,
  input  logic                   i_reload,
  input  logic [LEVEL_WIDTH-1:0] i_phase,
  input  logic                   i_load_en,
  input  logic [LEVEL_WIDTH-1:0] i_load_value,
  output logic                   o_pwm
);

  localparam int unsigned DCW = $clog2(DEBOUNCE_CYCLES + 1);

  logic [1:0]             r_sync1;
  logic [1:0]             r_sync2;
  logic [1:0]             r_deb;
  logic [DCW-1:0]         r_dcnt [2];
  logic                   r_prev_a;
  logic [LEVEL_WIDTH-1:0] r_shadow;
  logic [LEVEL_WIDTH-1:0] r_active;
  logic                   r_pwm;
  logic [1:0]             w_enc;
  logic                   w_rise;

  assign w_enc  = {i_enc_b, i_enc_a};
  assign w_rise = r_deb[0] & ~r_prev_a;
  assign o_pwm  = r_pwm;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_sync1 <= '0;
      r_sync2 <= '0;
    end else begin
      r_sync1 <= w_enc;
      r_sync2 <= r_sync1;
    end
  end

  // Bit 0 debounces A, bit 1 debounces B; any agreement restarts the count.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_deb <= '0;
      for (int k = 0; k < 2; k++) r_dcnt[k] <= '0;
    end else begin
      for (int k = 0; k < 2; k++) begin
        if (r_sync2[k] != r_deb[k]) begin
          if (r_dcnt[k] == DCW'(DEBOUNCE_CYCLES - 1)) begin
            r_deb[k]  <= r_sync2[k];
            r_dcnt[k] <= '0;
          end else begin
            r_dcnt[k] <= r_dcnt[k] + DCW'(1);
          end
        end else begin
          r_dcnt[k] <= '0;
        end
      end
    end
  end

  // A preset load wins over a same-cycle detent; active only follows at reload.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_prev_a <= 1'b0;
      r_shadow <= '0;
      r_active <= '0;
      r_pwm    <= 1'b0;
    end else begin
      r_prev_a <= r_deb[0];
      if (i_load_en) begin
        r_shadow <= i_load_value;
      end else if (w_rise) begin
        r_shadow <= LEVEL_WIDTH'(level_step(wide_level_t'(r_shadow), wide_level_t'(STEP),
                                            ~r_deb[1], SATURATE, LEVEL_WIDTH));
      end
      if (i_reload) r_active <= r_shadow;
      r_pwm <= (i_phase < r_active);
    end
  end

endmodule

// File: rtl/rgb_mixer_n.sv
// NUM_CHANNELS encoder-driven PWM mixer sharing one period counter.
// Define RGB_MIXER_PRESET_LOAD_EN to add the load_en/load_ch/load_value preset port.
module rgb_mixer_n import rgb_mixer_pkg::*; #(
  parameter int unsigned NUM_CHANNELS    = 3,
  parameter int unsigned LEVEL_WIDTH     = DEF_LEVEL_WIDTH,
  parameter int unsigned DEBOUNCE_CYCLES = DEF_DEBOUNCE_CYCLES,
  parameter int unsigned STEP            = DEF_STEP,
  parameter bit          SATURATE        = 1'b1,
  parameter int unsigned PHASE_STEP      = 0
) (
  input  logic                    clk,
  input  logic                    reset,
  input  logic [NUM_CHANNELS-1:0] enc_a,
  input  logic [NUM_CHANNELS-1:0] enc_b,
`ifdef RGB_MIXER_PRESET_LOAD_EN
  input  logic                    load_en,
  input  logic [((NUM_CHANNELS > 1) ? $clog2(NUM_CHANNELS) : 1)-1:0] load_ch,
  input  logic [LEVEL_WIDTH-1:0]  load_value,
`endif
  output logic [NUM_CHANNELS-1:0] pwm_out,
  output logic                    period_start
);

  localparam logic [LEVEL_WIDTH-1:0] CNT_MAX = '1;

  logic [LEVEL_WIDTH-1:0]  r_cnt;
  logic                    r_period_start;
  logic                    w_reload;
  logic [NUM_CHANNELS-1:0] w_load_en;
  logic [LEVEL_WIDTH-1:0]  w_load_value;

  assign w_reload     = (r_cnt == CNT_MAX);
  assign period_start = r_period_start;

  // period_start is high exactly while cnt sits at its maximum (the reload cycle).
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_cnt          <= '0;
      r_period_start <= 1'b0;
    end else begin
      r_cnt          <= r_cnt + LEVEL_WIDTH'(1);
      r_period_start <= (r_cnt == (CNT_MAX - LEVEL_WIDTH'(1)));
    end
  end

`ifdef RGB_MIXER_PRESET_LOAD_EN
  localparam int unsigned CH_W = (NUM_CHANNELS > 1) ? $clog2(NUM_CHANNELS) : 1;
  assign w_load_value = load_value;
  for (genvar g = 0; g < NUM_CHANNELS; g++) begin : g_load
    assign w_load_en[g] = load_en && (load_ch == CH_W'(g));
  end
`else
  assign w_load_value = '0;
  assign w_load_en    = '0;
`endif

  for (genvar g = 0; g < NUM_CHANNELS; g++) begin : g_ch
    logic [LEVEL_WIDTH-1:0] w_phase;
    assign w_phase = r_cnt + LEVEL_WIDTH'(g * PHASE_STEP);

    rgb_mixer_channel #(
      .LEVEL_WIDTH     (LEVEL_WIDTH),
      .DEBOUNCE_CYCLES (DEBOUNCE_CYCLES),
      .STEP            (STEP),
      .SATURATE        (SATURATE)
    ) u_ch (
      .clk          (clk),
      .reset        (reset),
      .i_enc_a      (enc_a[g]),
      .i_enc_b      (enc_b[g]),
      .i_reload     (w_reload),
      .i_phase      (w_phase),
      .i_load_en    (w_load_en[g]),
      .i_load_value (w_load_value),
      .o_pwm        (pwm_out[g])
    );
  end

endmodule

// File: tb/tb_rgb_mixer_n.sv
// Bench for rgb_mixer_n: a saturating aligned instance and a wrapping,
// phase-staggered instance share the same encoder stimulus.
module tb_rgb_mixer_n;
  import rgb_mixer_pkg::*;

  localparam int NCH    = 3;
  localparam int NLEV   = 256;
  localparam int WPHASE = 64;
  // Input to shadow-register latency: 2 sync flops + 7 debounce cycles + 1 write.
  localparam int PIPE   = 10;

  logic           clk = 1'b0;
  logic           reset = 1'b1;
  logic [NCH-1:0] enc_a = '0;
  logic [NCH-1:0] enc_b = '0;
  logic [NCH-1:0] pwm_s, pwm_w;
  logic           ps_s, ps_w;
`ifdef RGB_MIXER_PRESET_LOAD_EN
  logic           load_en = 1'b0;
  logic [1:0]     load_ch = '0;
  level_t         load_value = '0;
`endif

  int checks = 0;
  int errors = 0;
  int cyc = 0;
  int lvl_s [NCH];
  int lvl_w [NCH];
  int duty_s [NCH];
  int duty_w [NCH];

  always #5 clk = ~clk;

  always @(posedge clk or posedge reset) begin
    if (reset) cyc <= 0;
    else       cyc <= cyc + 1;
  end

  rgb_mixer_n #(.NUM_CHANNELS(NCH)) dut_s (
    .clk(clk), .reset(reset), .enc_a(enc_a), .enc_b(enc_b),
`ifdef RGB_MIXER_PRESET_LOAD_EN
    .load_en(load_en), .load_ch(load_ch), .load_value(load_value),
`endif
    .pwm_out(pwm_s), .period_start(ps_s)
  );

  rgb_mixer_n #(.NUM_CHANNELS(NCH), .SATURATE(1'b0), .PHASE_STEP(WPHASE)) dut_w (
    .clk(clk), .reset(reset), .enc_a(enc_a), .enc_b(enc_b),
`ifdef RGB_MIXER_PRESET_LOAD_EN
    .load_en(load_en), .load_ch(load_ch), .load_value(load_value),
`endif
    .pwm_out(pwm_w), .period_start(ps_w)
  );

  function automatic int sat_next(input int l, input bit dn);
    if (dn) return (l == 0) ? 0 : l - 1;
    return (l == NLEV - 1) ? l : l + 1;
  endfunction

  function automatic int wrap_next(input int l, input bit dn);
    return dn ? (l + NLEV - 1) % NLEV : (l + 1) % NLEV;
  endfunction

  task automatic clear_model();
    for (int c = 0; c < NCH; c++) begin
      lvl_s[c] = 0;
      lvl_w[c] = 0;
    end
  endtask

  // One clean detent on every channel in mask; dirs bit = B level (1 = down).
  task automatic detent(input logic [NCH-1:0] mask, input logic [NCH-1:0] dirs);
    enc_b = dirs;
    repeat (2) @(negedge clk);
    enc_a = mask;
    repeat (12) @(negedge clk);
    enc_a = '0;
    repeat (12) @(negedge clk);
    for (int c = 0; c < NCH; c++) begin
      if (mask[c]) begin
        lvl_s[c] = sat_next(lvl_s[c], dirs[c]);
        lvl_w[c] = wrap_next(lvl_w[c], dirs[c]);
      end
    end
  endtask

  // High-cycle count per channel over one full period after the next reload.
  task automatic measure_duty();
    for (int c = 0; c < NCH; c++) begin
      duty_s[c] = 0;
      duty_w[c] = 0;
    end
    @(negedge clk);
    while (cyc % NLEV != 1) @(negedge clk);
    for (int j = 0; j < NLEV; j++) begin
      for (int c = 0; c < NCH; c++) begin
        duty_s[c] += int'(pwm_s[c]);
        duty_w[c] += int'(pwm_w[c]);
      end
      @(negedge clk);
    end
  endtask

  task automatic test_reset();
    int bad_pwm, bad_ps, pulses;
    logic exp_ps;
    reset = 1'b1;
    enc_a = '0;
    enc_b = '0;
    clear_model();
    repeat (3) @(negedge clk);
    checks++;
    if (pwm_s !== '0 || pwm_w !== '0) begin
      errors++;
      $display("FAIL reset_pwm: got %b/%b expected 0/0", pwm_s, pwm_w);
    end
    checks++;
    if (ps_s !== 1'b0 || ps_w !== 1'b0) begin
      errors++;
      $display("FAIL reset_period_start: got %b/%b expected 0/0", ps_s, ps_w);
    end
    reset = 1'b0;
    bad_pwm = 0;
    bad_ps = 0;
    pulses = 0;
    for (int k = 0; k < 2 * NLEV; k++) begin
      @(negedge clk);
      exp_ps = (cyc % NLEV == NLEV - 1);
      if (pwm_s !== '0 || pwm_w !== '0) bad_pwm++;
      if (ps_s !== exp_ps || ps_w !== exp_ps) bad_ps++;
      if (ps_s === 1'b1) pulses++;
    end
    checks++;
    if (bad_pwm != 0) begin
      errors++;
      $display("FAIL idle_pwm: got %0d nonzero cycles expected 0", bad_pwm);
    end
    checks++;
    if (bad_ps != 0) begin
      errors++;
      $display("FAIL idle_period_start_timing: got %0d wrong cycles expected 0", bad_ps);
    end
    checks++;
    if (pulses != 2) begin
      errors++;
      $display("FAIL idle_period_start_count: got %0d expected 2", pulses);
    end
  endtask

  task automatic test_phase_and_async_reset();
    int rise_s [NCH];
    int rise_w [NCH];
    logic [NCH-1:0] prev_s, prev_w;
    int exp_w, n;
    repeat (32) detent('1, '0);
    measure_duty();
    for (int c = 0; c < NCH; c++) begin
      checks++;
      if (duty_s[c] != lvl_s[c] || duty_w[c] != lvl_w[c]) begin
        errors++;
        $display("FAIL phase_duty ch%0d: got %0d/%0d expected %0d/%0d",
                 c, duty_s[c], duty_w[c], lvl_s[c], lvl_w[c]);
      end
      rise_s[c] = -1;
      rise_w[c] = -1;
    end
    prev_s = pwm_s;
    prev_w = pwm_w;
    for (int j = 0; j < 2 * NLEV; j++) begin
      @(negedge clk);
      for (int c = 0; c < NCH; c++) begin
        if (rise_s[c] < 0 && pwm_s[c] === 1'b1 && prev_s[c] === 1'b0) rise_s[c] = cyc % NLEV;
        if (rise_w[c] < 0 && pwm_w[c] === 1'b1 && prev_w[c] === 1'b0) rise_w[c] = cyc % NLEV;
      end
      prev_s = pwm_s;
      prev_w = pwm_w;
    end
    for (int c = 0; c < NCH; c++) begin
      // Channel c is high while (cnt + c*64) mod 256 < level; output lags cnt by one.
      exp_w = (NLEV - (c * WPHASE) % NLEV + 1) % NLEV;
      checks++;
      if (rise_w[c] != exp_w) begin
        errors++;
        $display("FAIL phase_rise_staggered ch%0d: got %0d expected %0d", c, rise_w[c], exp_w);
      end
      checks++;
      if (rise_s[c] != 1) begin
        errors++;
        $display("FAIL phase_rise_aligned ch%0d: got %0d expected 1", c, rise_s[c]);
      end
    end
    n = 0;
    while (pwm_w[0] !== 1'b1 && n < 2 * NLEV) begin
      @(negedge clk);
      n++;
    end
    checks++;
    if (pwm_w[0] !== 1'b1) begin
      errors++;
      $display("FAIL async_reset_setup: got pwm %b expected high pulse", pwm_w[0]);
    end
    #2;
    reset = 1'b1;
    #1;
    checks++;
    if (pwm_s !== '0 || pwm_w !== '0 || ps_s !== 1'b0 || ps_w !== 1'b0) begin
      errors++;
      $display("FAIL async_reset_drop: got pwm %b/%b ps %b/%b expected all 0",
               pwm_s, pwm_w, ps_s, ps_w);
    end
    clear_model();
    @(negedge clk);
    reset = 1'b0;
  endtask

  task automatic test_single_detent();
    repeat (5) detent(3'b001, 3'b000);
    measure_duty();
    for (int c = 0; c < NCH; c++) begin
      checks++;
      if (duty_s[c] != lvl_s[c] || duty_w[c] != lvl_w[c]) begin
        errors++;
        $display("FAIL five_detents ch%0d: got %0d/%0d expected %0d/%0d",
                 c, duty_s[c], duty_w[c], lvl_s[c], lvl_w[c]);
      end
    end
  endtask

  task automatic test_glitch();
    enc_b = '0;
    enc_a = 3'b010;
    repeat (3) @(negedge clk);
    enc_a = '0;
    repeat (20) @(negedge clk);
    measure_duty();
    checks++;
    if (duty_s[1] != lvl_s[1] || duty_w[1] != lvl_w[1]) begin
      errors++;
      $display("FAIL glitch_ignored: got %0d/%0d expected %0d/%0d",
               duty_s[1], duty_w[1], lvl_s[1], lvl_w[1]);
    end
    enc_a = 3'b010;
    repeat (20) @(negedge clk);
    enc_a = '0;
    repeat (20) @(negedge clk);
    lvl_s[1] = sat_next(lvl_s[1], 1'b0);
    lvl_w[1] = wrap_next(lvl_w[1], 1'b0);
    measure_duty();
    checks++;
    if (duty_s[1] != lvl_s[1] || duty_w[1] != lvl_w[1]) begin
      errors++;
      $display("FAIL clean_pulse: got %0d/%0d expected %0d/%0d",
               duty_s[1], duty_w[1], lvl_s[1], lvl_w[1]);
    end
  endtask

  task automatic test_saturate_wrap();
    repeat (260) detent(3'b100, 3'b000);
    measure_duty();
    checks++;
    if (duty_s[2] != lvl_s[2] || duty_w[2] != lvl_w[2]) begin
      errors++;
      $display("FAIL up_260: got %0d/%0d expected %0d/%0d",
               duty_s[2], duty_w[2], lvl_s[2], lvl_w[2]);
    end
    repeat (300) detent(3'b100, 3'b100);
    measure_duty();
    checks++;
    if (duty_s[2] != lvl_s[2] || duty_w[2] != lvl_w[2]) begin
      errors++;
      $display("FAIL down_300: got %0d/%0d expected %0d/%0d",
               duty_s[2], duty_w[2], lvl_s[2], lvl_w[2]);
    end
  endtask

  task automatic test_boundary();
    int old_s, old_w, k_load, bad_s, bad_w;
    logic dn, exp_s, exp_w;
    dn = (lvl_s[0] >= NLEV / 2);
    enc_a = '0;
    enc_b[0] = dn;
    repeat (12) @(negedge clk);
    while (cyc % NLEV != NLEV - PIPE) @(negedge clk);
    k_load = cyc + PIPE;
    enc_a[0] = 1'b1;
    old_s = lvl_s[0];
    old_w = lvl_w[0];
    lvl_s[0] = sat_next(lvl_s[0], dn);
    lvl_w[0] = wrap_next(lvl_w[0], dn);
    while (cyc != k_load) @(negedge clk);
    bad_s = 0;
    bad_w = 0;
    for (int j = 1; j <= 2 * NLEV; j++) begin
      @(negedge clk);
      if (j == 4) enc_a[0] = 1'b0;
      if (j <= NLEV) begin
        exp_s = (j - 1 < old_s);
        exp_w = (j - 1 < old_w);
      end else begin
        exp_s = (j - 1 - NLEV < lvl_s[0]);
        exp_w = (j - 1 - NLEV < lvl_w[0]);
      end
      if (pwm_s[0] !== exp_s) bad_s++;
      if (pwm_w[0] !== exp_w) bad_w++;
    end
    checks++;
    if (bad_s != 0) begin
      errors++;
      $display("FAIL boundary_sat: got %0d wrong cycles expected 0 (old %0d new %0d)",
               bad_s, old_s, lvl_s[0]);
    end
    checks++;
    if (bad_w != 0) begin
      errors++;
      $display("FAIL boundary_wrap: got %0d wrong cycles expected 0 (old %0d new %0d)",
               bad_w, old_w, lvl_w[0]);
    end
  endtask

  task automatic test_random();
    logic [NCH-1:0] mask, dirs;
    for (int r = 0; r < 3; r++) begin
      for (int i = 0; i < 12; i++) begin
        mask = NCH'($urandom_range(0, 7));
        dirs = NCH'($urandom);
        detent(mask, dirs);
      end
      measure_duty();
      for (int c = 0; c < NCH; c++) begin
        checks++;
        if (duty_s[c] != lvl_s[c] || duty_w[c] != lvl_w[c]) begin
          errors++;
          $display("FAIL random_round%0d ch%0d: got %0d/%0d expected %0d/%0d",
                   r, c, duty_s[c], duty_w[c], lvl_s[c], lvl_w[c]);
        end
      end
    end
  endtask

  initial begin
    #3_000_000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog expired");
  end

  initial begin
    test_reset();
    test_phase_and_async_reset();
    test_single_detent();
    test_glitch();
    test_saturate_wrap();
    test_boundary();
    test_random();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
